serial_adder: RTL

- Bit-serial multi-bit adder built around the team's 1-bit full-adder cell (bit_addr) plus a carry flip-flop.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Feeds one bit pair per clock, LSB first, through the single adder cell.
- Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Downstream consumer of the bit_addr stage; area-cheap alternative to the parallel 8-bit ripple adder.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/bit_addr.sv | 13 +
 rtl/serial_adder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM states, default width
// and the sizing helper for the bit counter.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bit_addr.sv
// 1-bit full-adder cell; the serial adder reuses a single instance as its whole datapath.
module bit_addr (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock through a single bit_addr cell.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input for a - b (cout=1 means no borrow).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic [WIDTH-1:0] sum_nx;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cell_sum, cell_cout;
    logic             last;
    logic [WIDTH-1:0] load_b;
    logic             load_c;

    // Subtraction is a + ~b + 1, so it only changes what gets loaded.
`ifdef SERIAL_ADDER_SUB_EN
    assign load_b = sub ? ~b : b;
    assign load_c = sub | cin;
`else
    assign load_b = b;
    assign load_c = cin;
`endif

    assign last   = (cnt == CW'(WIDTH - 1));
    assign sum_nx = {cell_sum, sum_sh};

    bit_addr u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Result registers load only on the final shift so they stay stable in DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= load_b;
                        carry <= load_c;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_nx[WIDTH-1:1];
                    carry  <= cell_cout;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        sum  <= sum_nx;
                        cout <= cell_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
